// File: rtl/ikaopll_acc_mixer_if.sv
// Sample/volume/result bundle for the IKAOPLL accumulating output mixer.
// The master drives samples and control; the slave (the mixer) returns frame results.
interface ikaopll_acc_mixer_if #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CH_IDX_W  = 1,
    parameter int unsigned IN_WIDTH  = 9,
    parameter int unsigned VOL_WIDTH = 5,
    parameter int unsigned OUT_WIDTH = 16
);
    logic                          i_FRAME;
    logic                          i_SMP_VALID;
    logic [CH_IDX_W-1:0]           i_SMP_CH;
    logic [IN_WIDTH-1:0]           i_SMP_DATA;
    logic [NUM_CH*VOL_WIDTH-1:0]   i_VOL;
    logic                          i_CLIP_CLR;
    logic                          o_ACC_STRB;
    logic [OUT_WIDTH-1:0]          o_ACC;
    logic                          o_CLIP;
    logic [5:0]                    o_SMP_CNT;

    modport master (
        output i_FRAME, i_SMP_VALID, i_SMP_CH, i_SMP_DATA, i_VOL, i_CLIP_CLR,
        input  o_ACC_STRB, o_ACC, o_CLIP, o_SMP_CNT
    );

    modport slave (
        input  i_FRAME, i_SMP_VALID, i_SMP_CH, i_SMP_DATA, i_VOL, i_CLIP_CLR,
        output o_ACC_STRB, o_ACC, o_CLIP, o_SMP_CNT
    );
endinterface

// File: rtl/ikaopll_acc_mixer.sv
// Multi-channel volume-weighted accumulating output mixer: sign-magnitude samples are
// scaled per channel, summed over a frame and emitted as a saturated/wrapped signed result.
module ikaopll_acc_mixer #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CH_IDX_W  = 1,
    parameter int unsigned IN_WIDTH  = 9,
    parameter int unsigned VOL_WIDTH = 5,
    parameter int unsigned OUT_WIDTH = 16,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic                 i_EMUCLK,
    input  logic                 i_RST_n,
    input  logic                 i_phi1_NCEN_n,
    ikaopll_acc_mixer_if.slave   bus
);
    localparam int unsigned PROD_W = IN_WIDTH + VOL_WIDTH;
    localparam int unsigned ACC_W  = PROD_W + 5;
    localparam int unsigned EXT_W  = ACC_W + OUT_WIDTH;

    logic                        en;
    logic [IN_WIDTH-2:0]         mag;
    logic [VOL_WIDTH-1:0]        vol_sel;
    logic signed [PROD_W-1:0]    smp_ext;
    logic signed [PROD_W-1:0]    vol_ext;
    logic signed [PROD_W-1:0]    mul;
    logic                        accept;
    logic signed [ACC_W-1:0]     prod_add;
    logic signed [ACC_W-1:0]     fin;
    logic [EXT_W-1:0]            fin_ext;
    logic [EXT_W-OUT_WIDTH:0]    hi;
    logic                        ovf;
    logic [OUT_WIDTH-1:0]        res;
    logic [5:0]                  cnt_inc;

    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [PROD_W-1:0]    prod_q, prod_d;
    logic                        pv_q, pv_d;
    logic [5:0]                  cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]        out_q, out_d;
    logic                        strb_q, strb_d;
    logic                        clip_q, clip_d;
    logic [5:0]                  cnt_out_q, cnt_out_d;

    assign en = ~i_phi1_NCEN_n;

    // Stage 1: sign-magnitude to two's complement, then signed multiply by channel volume
    always_comb begin
        mag     = bus.i_SMP_DATA[IN_WIDTH-2:0];
        smp_ext = {{(VOL_WIDTH+1){1'b0}}, mag};
        if (bus.i_SMP_DATA[IN_WIDTH-1]) begin
            smp_ext = -smp_ext;
        end
        vol_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (32'(bus.i_SMP_CH) == k) begin
                vol_sel = bus.i_VOL[k*VOL_WIDTH +: VOL_WIDTH];
            end
        end
        vol_ext = {{IN_WIDTH{vol_sel[VOL_WIDTH-1]}}, vol_sel};
        mul     = smp_ext * vol_ext;
        accept  = bus.i_SMP_VALID && (32'(bus.i_SMP_CH) < NUM_CH);
    end

    // Frame result: the in-flight stage-2 product still belongs to the closing frame
    always_comb begin
        prod_add = pv_q ? {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q} : '0;
        fin      = acc_q + prod_add;
        fin_ext  = {{OUT_WIDTH{fin[ACC_W-1]}}, fin};
        hi       = fin_ext[EXT_W-1:OUT_WIDTH-1];
        ovf      = !((&hi) || (~|hi));
        if (SATURATE && ovf) begin
            res = fin[ACC_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
            res = fin_ext[OUT_WIDTH-1:0];
        end
        cnt_inc = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
    end

    always_comb begin
        acc_d     = acc_q;
        prod_d    = prod_q;
        pv_d      = pv_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        strb_d    = 1'b0;
        clip_d    = clip_q;
        cnt_out_d = cnt_out_q;
        if (en) begin
            pv_d   = accept;
            prod_d = accept ? mul : prod_q;
            if (bus.i_FRAME) begin
                acc_d     = '0;
                out_d     = res;
                cnt_out_d = cnt_q;
                cnt_d     = accept ? 6'd1 : 6'd0;
                strb_d    = 1'b1;
            end else begin
                acc_d = fin;
                cnt_d = accept ? cnt_inc : cnt_q;
            end
            if (bus.i_FRAME && ovf) begin
                clip_d = 1'b1;
            end else if (bus.i_CLIP_CLR) begin
                clip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            acc_q     <= '0;
            prod_q    <= '0;
            pv_q      <= 1'b0;
            cnt_q     <= '0;
            out_q     <= '0;
            strb_q    <= 1'b0;
            clip_q    <= 1'b0;
            cnt_out_q <= '0;
        end else begin
            acc_q     <= acc_d;
            prod_q    <= prod_d;
            pv_q      <= pv_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            strb_q    <= strb_d;
            clip_q    <= clip_d;
            cnt_out_q <= cnt_out_d;
        end
    end

    assign bus.o_ACC      = out_q;
    assign bus.o_ACC_STRB = strb_q;
    assign bus.o_CLIP     = clip_q;
    assign bus.o_SMP_CNT  = cnt_out_q;
endmodule
